// File: rtl/cfg_dispatch_pkg.sv
// Shared types for the config stream dispatcher.
// State encoding, header field layout and end-of-list id.
package cfg_dispatch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WAIT,
    S_FIN
  } state_e;

  // Header: id in the top ID_W bits, count at LEN_LSB
  localparam int ID_W    = 8;
  localparam int LEN_LSB = 0;

  localparam logic [ID_W-1:0] END_ID = 8'hFF;

endpackage

// File: rtl/cfg_dispatch_out_reg.sv
// One-entry registered output stage (cfg_out_reg).
// Holds data while the consumer stalls.
module cfg_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign in_ready_o  = !vld_q || out_ready_i;
  assign out_valid_o = vld_q;
  assign out_data_o  = data_q;

  // load on accept, drain when consumed
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (in_valid_i && in_ready_o) begin
      vld_d  = 1'b1;
      data_d = in_data_i;
    end else if (out_ready_i) begin
      vld_d = 1'b0;
    end
  end

  // stage register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/cfg_stream_dispatch.sv
// Config stream dispatcher: header/payload words to N destinations.
// Optional done timeout in WAIT: define CFG_DONE_TIMEOUT_EN.
module cfg_stream_dispatch #(
  parameter int DATA_W   = 32,
  parameter int NUM_DEST = 4,
  parameter int LEN_W    = 10,
  parameter int TMO_CYC  = 4096
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [DATA_W-1:0]   cfg_data,
  output logic                cfg_ready,
  output logic                cfg_ack,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic [NUM_DEST-1:0] dst_start,
  output logic [NUM_DEST-1:0] dst_valid,
  output logic [DATA_W-1:0]   dst_data,
  input  logic [NUM_DEST-1:0] dst_ready,
  input  logic [NUM_DEST-1:0] dst_done
);
  import cfg_dispatch_pkg::*;

  localparam logic [ID_W:0] NDEST = 9'(NUM_DEST);

  state_e              state_q, state_d;
  logic [NUM_DEST-1:0] sel_q, sel_d;
  logic [NUM_DEST-1:0] start_q, start_d;
  logic [NUM_DEST-1:0] hdr_oh;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                err_q, err_d;
  logic [ID_W-1:0]     hid;
  logic [LEN_W-1:0]    hlen;
  logic                or_in_valid, or_in_ready, or_out_valid;
  logic                sel_rdy, sel_done, in_fire, last_xfer;

`ifdef CFG_DONE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign hid  = cfg_data[DATA_W-1 -: ID_W];
  assign hlen = cfg_data[LEN_LSB +: LEN_W];

  assign sel_rdy  = |(dst_ready & sel_q);
  assign sel_done = |(dst_done & sel_q);

  assign or_in_valid = cfg_valid && (state_q == S_DATA)
                    && (rem_q != '0);
  assign in_fire     = or_in_valid && or_in_ready;
  assign last_xfer   = (state_q == S_DATA) && (rem_q == '0)
                    && or_out_valid && sel_rdy;

  assign cfg_ready = (state_q == S_HDR)
                  || ((state_q == S_DATA) && (rem_q != '0)
                      && or_in_ready);
  assign cfg_ack   = (state_q != S_IDLE);
  assign cfg_done  = (state_q == S_FIN);
  assign cfg_err   = err_q;
  assign dst_start = start_q;
  assign dst_valid = or_out_valid ? sel_q : '0;

  cfg_out_reg #(
    .DATA_W (DATA_W)
  ) u_out (
    .CLK         (CLK),
    .nRST        (nRST),
    .in_valid_i  (or_in_valid),
    .in_data_i   (cfg_data),
    .in_ready_o  (or_in_ready),
    .out_valid_o (or_out_valid),
    .out_data_o  (dst_data),
    .out_ready_i (sel_rdy)
  );

  // one-hot decode of the header destination id
  always_comb begin
    hdr_oh = '0;
    for (int i = 0; i < NUM_DEST; i++)
      hdr_oh[i] = (hid == ID_W'(i));
  end

  // session sequencing, header decode and word counting
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    err_d   = err_q;
    start_d = '0;
`ifdef CFG_DONE_TIMEOUT_EN
    tmo_d   = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = S_HDR;
          err_d   = 1'b0;
        end
      end
      S_HDR: begin
        if (cfg_valid) begin
          if (hid == END_ID) begin
            state_d = S_FIN;
          end else if ({1'b0, hid} >= NDEST) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (hlen != '0) begin
            sel_d   = hdr_oh;
            start_d = hdr_oh;
            rem_d   = hlen;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (in_fire)
          rem_d = rem_q - 1'b1;
        // a done seen with the last transfer skips WAIT
        if (last_xfer)
          state_d = sel_done ? S_HDR : S_WAIT;
      end
      S_WAIT: begin
        if (sel_done) begin
          state_d = S_HDR;
`ifdef CFG_DONE_TIMEOUT_EN
        end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // control state registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      start_q <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

`ifdef CFG_DONE_TIMEOUT_EN
  // cycles spent waiting for the selected done
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

endmodule

// File: tb/tb_cfg_stream_dispatch.sv
// Bench for cfg_stream_dispatch: table rows, random sessions
// against a session-level model, and reset/timeout sequences.
module tb_cfg_stream_dispatch;

  localparam int DW = 32;
  localparam int ND = 4;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [DW-1:0] cfg_data = '0;
  logic          cfg_ready, cfg_ack, cfg_done, cfg_err;
  logic [ND-1:0] dst_start, dst_valid;
  logic [DW-1:0] dst_data;
  logic [ND-1:0] dst_ready = '0;
  logic [ND-1:0] dst_done = '0;

  always #5 CLK = ~CLK;

  cfg_stream_dispatch #(
    .DATA_W   (DW),
    .NUM_DEST (ND),
    .LEN_W    (10),
    .TMO_CYC  (16)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .cfg_ack   (cfg_ack),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .dst_start (dst_start),
    .dst_valid (dst_valid),
    .dst_data  (dst_data),
    .dst_ready (dst_ready),
    .dst_done  (dst_done)
  );

  typedef struct { int d; logic [31:0] w; } xfer_t;

  typedef struct {
    int id0, n0, id1, n1, id2, n2;
    int rdy, stall, dly;
    int ewords;
    bit eerr;
    logic [3:0] emask;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] src_q[$];
  xfer_t exp_q[$], got_q[$];
  int exp_st[$], got_st[$];
  int seg_id[$], seg_n[$];
  int h_id[$], h_n[$];
  bit exp_err, force_err;

  int rdy_pct = 100, src_pct = 100, done_dly = 0;
  int stall_after = -1, stall_left = 0;
  int cur_id = -1, cur_left = 0, timer = -1;
  bit start_req = 0, in_sess = 0;
  int done_cnt = 0, last_x = 0, done_at = 0;
  logic [3:0]  prev_v = '0, prev_r = '0;
  logic [31:0] prev_d = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // one clock: drive source/sink at negedge, sample 1ns later
  task automatic step();
    logic [3:0] fire;
    @(negedge CLK);
    cyc++;
    cfg_start = start_req;
    start_req = 0;
    cfg_valid = (src_q.size() != 0)
             && ($urandom_range(0, 99) < src_pct);
    cfg_data  = cfg_valid ? src_q[0] : $urandom;
    for (int i = 0; i < ND; i++)
      dst_ready[i] = ($urandom_range(0, 99) < rdy_pct);
    if (stall_left > 0) begin
      dst_ready = '0;
      stall_left--;
    end
    if (cur_id < 0 && seg_id.size() != 0) begin
      cur_id   = seg_id.pop_front();
      cur_left = seg_n.pop_front();
    end
    dst_done = 4'($urandom) & 4'($urandom);
    if (cur_id >= 0) dst_done[cur_id] = 1'b0;
    fire = dst_valid & dst_ready;
    if (cur_id >= 0 && cur_left > 0 && fire[cur_id]) begin
      cur_left--;
      if (cur_left == 0) timer = done_dly;
    end
    if (timer == 0 && cur_id >= 0) begin
      dst_done[cur_id] = 1'b1;
      timer  = -1;
      cur_id = -1;
    end else if (timer > 0) begin
      timer--;
    end
    #1;
    chk("valid_onehot", 64'($onehot0(dst_valid)), 1);
    if ((prev_v & ~prev_r) != 0) begin
      chk("hold_data", dst_data, prev_d);
      chk("hold_valid", dst_valid, prev_v);
    end
    if ((dst_valid & ~dst_ready) != 0)
      chk("stall_ready", cfg_ready, 0);
    if (!in_sess) begin
      chk("idle_valid", dst_valid, 0);
      chk("idle_start", dst_start, 0);
    end
    prev_v = dst_valid;
    prev_r = dst_ready;
    prev_d = dst_data;
    if (cfg_valid && cfg_ready) void'(src_q.pop_front());
    if (fire != 0) begin
      got_q.push_back('{$clog2(fire), dst_data});
      last_x = cyc;
      if (got_q.size() == stall_after) begin
        stall_left  = 5;
        stall_after = -1;
      end
    end
    for (int i = 0; i < ND; i++)
      if (dst_start[i]) got_st.push_back(i);
    if (cfg_done) begin
      done_cnt++;
      done_at = cyc;
    end
  endtask

  // session model: what a header list must produce downstream
  task automatic prep();
    bit stop, live;
    logic [31:0] w;
    src_q.delete(); exp_q.delete(); got_q.delete();
    exp_st.delete(); got_st.delete();
    seg_id.delete(); seg_n.delete();
    cur_id = -1; timer = -1; stall_left = 0;
    exp_err = 0; done_cnt = 0; stop = 0;
    for (int k = 0; k < h_id.size(); k++) begin
      w = $urandom;
      w[31:24] = 8'(h_id[k]);
      w[9:0]   = 10'(h_n[k]);
      src_q.push_back(w);
      live = 0;
      if (!stop) begin
        if (h_id[k] == 255) stop = 1;
        else if (h_id[k] >= ND) begin
          exp_err = 1;
          stop = 1;
        end else if (h_n[k] > 0) begin
          live = 1;
          exp_st.push_back(h_id[k]);
          seg_id.push_back(h_id[k]);
          seg_n.push_back(h_n[k]);
        end
      end
      for (int j = 0; j < h_n[k]; j++) begin
        w = $urandom;
        src_q.push_back(w);
        if (live) exp_q.push_back('{h_id[k], w});
      end
    end
    if (force_err) exp_err = 1;
  endtask

  task automatic run_session();
    int budget;
    prep();
    start_req = 1;
    in_sess = 1;
    step();
    step();
    chk("ack_high", cfg_ack, 1);
    chk("err_cleared", cfg_err, 0);
    budget = 0;
    while (done_cnt == 0 && budget < 3000) begin
      step();
      budget++;
    end
    if (done_cnt == 0) chk("session_timeout", 0, 1);
    step();
    in_sess = 0;
    chk("ack_low", cfg_ack, 0);
    chk("done_once", done_cnt, 1);
    chk("err_flag", cfg_err, exp_err);
    chk("n_words", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk("word_dst", got_q[i].d, exp_q[i].d);
      chk("word_data", got_q[i].w, exp_q[i].w);
    end
    chk("n_starts", got_st.size(), exp_st.size());
    for (int i = 0; i < got_st.size() && i < exp_st.size(); i++)
      chk("start_id", got_st[i], exp_st[i]);
  endtask

  task automatic hdrs(input int a, input int na, input int b,
                      input int nb, input int c, input int nc);
    h_id.delete(); h_n.delete();
    if (a >= 0) begin h_id.push_back(a); h_n.push_back(na); end
    if (b >= 0) begin h_id.push_back(b); h_n.push_back(nb); end
    if (c >= 0) begin h_id.push_back(c); h_n.push_back(nc); end
  endtask

  function automatic vec_t mk(int i0, int n0, int i1, int n1,
                              int i2, int n2, int rdy, int st,
                              int dly, int ew, bit ee,
                              logic [3:0] em);
    vec_t v;
    v.id0 = i0; v.n0 = n0; v.id1 = i1; v.n1 = n1;
    v.id2 = i2; v.n2 = n2; v.rdy = rdy; v.stall = st;
    v.dly = dly; v.ewords = ew; v.eerr = ee; v.emask = em;
    return v;
  endfunction

  vec_t tbl[7];

  initial begin
    logic [3:0] mask;
    int budget;
    force_err = 0;
    tbl[0] = mk(1, 3, 255, 0, -1, 0, 100, -1, 2, 3, 0, 4'b0010);
    tbl[1] = mk(0, 4, 255, 0, -1, 0, 100, 2, 0, 4, 0, 4'b0001);
    tbl[2] = mk(7, 2, 255, 0, -1, 0, 100, -1, 1, 0, 1, 4'b0000);
    tbl[3] = mk(2, 0, 3, 1, 255, 0, 100, -1, 1, 1, 0, 4'b1000);
    tbl[4] = mk(0, 1, 2, 2, 255, 0, 50, -1, 0, 3, 0, 4'b0101);
    tbl[5] = mk(255, 5, -1, 0, -1, 0, 100, -1, 0, 0, 0, 4'b0000);
    tbl[6] = mk(3, 5, 4, 1, 255, 0, 70, -1, 3, 5, 1, 4'b1000);

    repeat (2) @(negedge CLK);
    #1;
    chk("rst_ready", cfg_ready, 0);
    chk("rst_ack", cfg_ack, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_start", dst_start, 0);
    chk("rst_valid", dst_valid, 0);
    chk("rst_data", dst_data, 0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (3) step();

    for (int r = 0; r < 7; r++) begin
      hdrs(tbl[r].id0, tbl[r].n0, tbl[r].id1, tbl[r].n1,
           tbl[r].id2, tbl[r].n2);
      rdy_pct = tbl[r].rdy;
      src_pct = 100;
      stall_after = tbl[r].stall;
      done_dly = tbl[r].dly;
      run_session();
      chk("tbl_words", got_q.size(), tbl[r].ewords);
      chk("tbl_err", cfg_err, tbl[r].eerr);
      mask = '0;
      foreach (got_st[i]) mask[got_st[i]] = 1'b1;
      chk("tbl_starts", mask, tbl[r].emask);
    end

    for (int s = 0; s < 40; s++) begin
      int nh;
      h_id.delete(); h_n.delete();
      nh = $urandom_range(1, 3);
      for (int k = 0; k < nh; k++) begin
        h_id.push_back(($urandom_range(0, 9) == 0)
                       ? $urandom_range(4, 254)
                       : $urandom_range(0, 3));
        h_n.push_back($urandom_range(0, 6));
      end
      h_id.push_back(255);
      h_n.push_back($urandom_range(0, 3));
      rdy_pct = $urandom_range(30, 100);
      src_pct = $urandom_range(40, 100);
      done_dly = $urandom_range(0, 3);
      stall_after = ($urandom_range(0, 1) != 0) ? 1 : -1;
      run_session();
    end

    // reset in the middle of a payload
    hdrs(0, 5, 255, 0, -1, 0);
    rdy_pct = 100; src_pct = 100; done_dly = 1; stall_after = -1;
    prep();
    start_req = 1;
    in_sess = 1;
    budget = 0;
    while (got_q.size() < 2 && budget < 200) begin
      step();
      budget++;
    end
    chk("rst_mid_reached", got_q.size(), 2);
    #2 nRST = 1'b0;
    #1;
    chk("mrst_ready", cfg_ready, 0);
    chk("mrst_ack", cfg_ack, 0);
    chk("mrst_done", cfg_done, 0);
    chk("mrst_err", cfg_err, 0);
    chk("mrst_start", dst_start, 0);
    chk("mrst_valid", dst_valid, 0);
    chk("mrst_data", dst_data, 0);
    src_q.delete(); seg_id.delete(); seg_n.delete();
    cur_id = -1; timer = -1;
    in_sess = 0;
    prev_v = '0; prev_r = '0;
    @(negedge CLK);
    nRST = 1'b1;
    repeat (5) step();
    hdrs(2, 4, 255, 0, -1, 0);
    run_session();
    chk("post_rst_words", got_q.size(), 4);

`ifdef CFG_DONE_TIMEOUT_EN
    hdrs(1, 2, 255, 0, -1, 0);
    rdy_pct = 100; done_dly = -1; force_err = 1;
    run_session();
    force_err = 0;
    chk("tmo_err", cfg_err, 1);
    chk("tmo_latency", done_at - last_x, 17);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_stream_dispatch.md
CFG_STREAM_DISPATCH -- requirements
Module: cfg_stream_dispatch

Interface
REQ-001 Parameter DATA_W, default 32: config word width.
REQ-002 Parameter NUM_DEST, default 4, range 1..255: number of downstream destinations.
REQ-003 Parameter LEN_W, default 10: word-count field width; LEN_W <= DATA_W-8.
REQ-004 Parameter TMO_CYC, default 4096: done-timeout limit in cycles; used only when CFG_DONE_TIMEOUT_EN is defined.
REQ-005 CLK  in  1  clock; all logic on rising edge.
REQ-006 nRST  in  1  reset, asynchronous, active-low.
REQ-007 cfg_start  in  1  single-cycle request to begin a configuration session.
REQ-008 cfg_valid  in  1  cfg_data valid.
REQ-009 cfg_data  in  DATA_W  header or payload word.
REQ-010 cfg_ready  out  1  word accepted when cfg_valid && cfg_ready.
REQ-011 cfg_ack  out  1  high from session accept until the session ends.
REQ-012 cfg_done  out  1  one-cycle pulse at session end.
REQ-013 cfg_err  out  1  sticky error flag, cleared by the next accepted cfg_start.
REQ-014 dst_start  out  NUM_DEST  one-cycle pulse to the selected destination before its first payload word.
REQ-015 dst_valid  out  NUM_DEST  one-hot payload valid.
REQ-016 dst_data  out  DATA_W  payload, shared by all destinations.
REQ-017 dst_ready  in  NUM_DEST  per-destination ready.
REQ-018 dst_done  in  NUM_DEST  per-destination completion pulse or level.

Function
REQ-019 FSM states: IDLE, HDR, DATA, WAIT, FIN.
- IDLE -> HDR on cfg_start.
- Otherwise FSM state changes only as stated below.
REQ-020 cfg_start outside IDLE is ignored.
REQ-021 Header word fields:
- [DATA_W-1:DATA_W-8] = destination id.
- [LEN_W-1:0] = payload count N.
- Other bits are ignored.
REQ-022 Header handling in HDR:
- id 8'hFF is end-of-list and goes to FIN.
- id >= NUM_DEST sets cfg_err and goes to FIN.
- N == 0 is skipped and stays in HDR.
- Otherwise the id and N are latched, dst_start[id] pulses the next cycle, and the FSM goes to DATA.
REQ-023 In DATA, exactly N words are forwarded to destination id.
- dst_data and dst_valid are registered: one-cycle latency from input acceptance.
REQ-024 Output register holds while dst_valid[id] && !dst_ready[id].
- cfg_ready = (state==HDR) || (state==DATA && remaining>0 && (output empty || dst_ready[id])).
- Throughput is one word per cycle with no bubbles.
REQ-025 After the Nth word is consumed downstream, go to WAIT.
- WAIT -> HDR on dst_done[id].
- dst_done arriving in the same cycle as the last transfer is honoured; it is not lost.
REQ-026 FIN: cfg_done pulses one cycle, cfg_ack deasserts, then IDLE.
REQ-027 Remaining-word counter is LEN_W bits and decrements on each accepted input; it never wraps below 0.
REQ-028 dst_done from any non-selected destination is ignored.

Reset
REQ-029 On nRST low, all of the following are reset asynchronously:
- State = IDLE.
- cfg_ready, cfg_ack, cfg_done, cfg_err = 0.
- dst_start, dst_valid = 0; dst_data = 0.
- Counters = 0.
REQ-030 Reset mid-session discards any partial transfer; no dst_start or dst_valid appears until a new cfg_start.

Configuration
REQ-031 Macro CFG_DONE_TIMEOUT_EN defined:
- In WAIT, a counter runs; if TMO_CYC cycles pass without dst_done[id], set cfg_err and go to FIN.
REQ-032 CFG_DONE_TIMEOUT_EN undefined: no counter logic; WAIT waits indefinitely.

Structure
REQ-033 Shared package cfg_dispatch_pkg holds:
- State enum.
- Header field positions.
- END_ID constant 8'hFF.
REQ-034 Sub-module cfg_out_reg: one-entry registered output stage (valid/ready/data hold). All other logic is in the top.

Verification
REQ-035 Defaults. Input: cfg_start, header {id=1,N=3}, 3 words, dst_done[1], header 0xFF. Required:
- dst_start[1] pulses once.
- 3 words reach dst_data with dst_valid[1] only.
- cfg_done pulses once, then cfg_ack=0.
REQ-036 Backpressure: dst_ready[0]=0 for 5 cycles mid-payload (N=4). Required:
- dst_data is stable during the stall.
- cfg_ready=0 during the stall.
- No word is lost or duplicated.
REQ-037 Headers {id=7,N=2} with NUM_DEST=4. Required: cfg_err=1, FIN reached, no dst_valid; the next cfg_start clears cfg_err.
REQ-038 Headers {id=2,N=0}, then {id=3,N=1}. Required: no dst_start[2]; dst_start[3] and one word are delivered.
REQ-039 nRST pulsed after 2 of 5 words. Required: all outputs are 0, state is IDLE, and a subsequent full session succeeds.
REQ-040 With CFG_DONE_TIMEOUT_EN and TMO_CYC=16: dst_done is withheld. Required: cfg_err=1 and cfg_done pulse 16 cycles after entering WAIT.
